// File: rtl/alu_pkg.sv
// Shared opcode, width and port-index constants for the ALU and its arbiter.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic PORT_EX = 1'b0;
    localparam logic PORT_AG = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/sub/and/or, shifts of operand b, signed/unsigned set-less-than.
module alu
    import alu_pkg::*;
#(
    parameter int W  = alu_pkg::WIDTH,
    parameter int SW = alu_pkg::SHW
) (
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic [2:0]    i_f,
    input  logic [SW-1:0] i_shamt,
    output logic [W-1:0]  o_res,
    output logic          o_zero
);

    always_comb begin
        o_res = '0;
        case (i_f)
            ALU_ADD:  o_res = i_a + i_b;
            ALU_SUB:  o_res = i_a - i_b;
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_SLL:  o_res = i_b << i_shamt;
            ALU_SRL:  o_res = i_b >> i_shamt;
            ALU_SLT:  o_res = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_res = {{(W-1){1'b0}}, (i_a < i_b)};
            default:  o_res = '0;
        endcase
    end

    assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the EX port (0) and the address/branch port (1).
// Optional per-port stall counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int SHW   = alu_pkg::SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic             rsp1_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]      wait0_cnt,
    output logic [15:0]      wait1_cnt
`endif
);
    import alu_pkg::*;

    logic [1:0]            w_req_valid;
    logic [1:0]            w_rsp_ready;
    logic [1:0]            w_elig;
    logic [1:0]            w_gnt;
    logic [1:0]            w_rsp_valid;
    logic [1:0]            w_rsp_zero;
    logic [1:0][WIDTH-1:0] w_rsp_res;
    logic                  w_sel;
    logic [WIDTH-1:0]      w_alu_a;
    logic [WIDTH-1:0]      w_alu_b;
    logic [2:0]            w_alu_f;
    logic [SHW-1:0]        w_alu_shamt;
    logic [WIDTH-1:0]      w_alu_res;
    logic                  w_alu_zero;
    logic                  r_last;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    // Ties go to the port that did not win most recently; r_last resets to PORT_AG.
    assign w_gnt[0] = !reset && w_elig[0] && (!w_elig[1] || r_last == PORT_AG);
    assign w_gnt[1] = !reset && w_elig[1] && (!w_elig[0] || r_last == PORT_EX);
    assign w_sel    = w_gnt[1];

    assign w_alu_a     = w_sel ? req1_a     : req0_a;
    assign w_alu_b     = w_sel ? req1_b     : req0_b;
    assign w_alu_f     = w_sel ? req1_f     : req0_f;
    assign w_alu_shamt = w_sel ? req1_shamt : req0_shamt;

    alu #(
        .W  (WIDTH),
        .SW (SHW)
    ) u_alu (
        .i_a     (w_alu_a),
        .i_b     (w_alu_b),
        .i_f     (w_alu_f),
        .i_shamt (w_alu_shamt),
        .o_res   (w_alu_res),
        .o_zero  (w_alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= PORT_AG;
        end else if (w_gnt != 2'b00) begin
            r_last <= w_gnt[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic             r_valid;
            logic [WIDTH-1:0] r_res;
            logic             r_zero;

            // A slot being drained this cycle may be refilled in the same cycle.
            assign w_elig[gi] = w_req_valid[gi] && (!r_valid || w_rsp_ready[gi]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_res   <= '0;
                    r_zero  <= 1'b0;
                end else if (w_gnt[gi]) begin
                    r_valid <= 1'b1;
                    r_res   <= w_alu_res;
                    r_zero  <= w_alu_zero;
                end else if (w_rsp_ready[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_rsp_valid[gi] = r_valid;
            assign w_rsp_res[gi]   = r_res;
            assign w_rsp_zero[gi]  = r_zero;
        end
    endgenerate

`ifdef ALU_ARB_STATS_EN
    logic [1:0][15:0] w_wait_cnt;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic [15:0] r_wait_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wait_cnt <= '0;
                end else if (w_req_valid[gi] && !w_gnt[gi] && r_wait_cnt != 16'hFFFF) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                end
            end

            assign w_wait_cnt[gi] = r_wait_cnt;
        end
    endgenerate

    assign wait0_cnt = w_wait_cnt[0];
    assign wait1_cnt = w_wait_cnt[1];
`endif

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];
    assign rsp0_valid = w_rsp_valid[0];
    assign rsp1_valid = w_rsp_valid[1];
    assign rsp0_res   = w_rsp_res[0];
    assign rsp1_res   = w_rsp_res[1];
    assign rsp0_zero  = w_rsp_zero[0];
    assign rsp1_zero  = w_rsp_zero[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter; stall-counter checks run when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_res, rsp1_res;
    logic        rsp0_zero, rsp1_zero;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] wait0_cnt, wait1_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .req1_shamt (req1_shamt),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_res   (rsp0_res),
        .rsp0_zero  (rsp0_zero),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_res   (rsp1_res),
        .rsp1_zero  (rsp1_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .wait0_cnt  (wait0_cnt),
        .wait1_cnt  (wait1_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
        req0_valid = v; req0_f = f; req0_a = a; req0_b = b; req0_shamt = sh;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
        req1_valid = v; req1_f = f; req1_a = a; req1_b = b; req1_shamt = sh;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        settle();
    endtask

    logic [31:0] exp_sll [4];
    logic [1:0]  exp_alt [4];

    initial begin
        exp_sll = '{32'd1, 32'd2, 32'd4, 32'd8};
        exp_alt = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req0(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0);
        set_req1(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0);
        step();
        check_eq("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        check_eq("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        check_eq("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check_eq("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check_eq("reset_rsp0_res", rsp0_res, 32'd0);
        check_eq("reset_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
        apply_reset();

        // Single op: add with signed overflow wraps.
        set_req0(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
        settle();
        check_eq("single_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        settle();
        check_eq("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check_eq("single_rsp0_res", rsp0_res, 32'h8000_0000);
        check_eq("single_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
        rsp0_ready = 1'b1;
        step();
        check_eq("drain_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check_eq("drain_rsp0_res_kept", rsp0_res, 32'h8000_0000);

        // Tie straight after reset: port 0 first.
        apply_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req0(1'b1, ALU_SUB, 32'd5, 32'd5, 5'd0);
        set_req1(1'b1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0);
        settle();
        check_eq("tie_c0_req0_ready", {31'd0, req0_ready}, 32'd1);
        check_eq("tie_c0_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        settle();
        check_eq("tie_c1_rsp0_res", rsp0_res, 32'd0);
        check_eq("tie_c1_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
        check_eq("tie_c1_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        settle();
        check_eq("tie_c2_rsp1_res", rsp1_res, 32'd1);
        check_eq("tie_c2_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);

        // Continuous contention alternates grants.
        set_req0(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        set_req1(1'b1, ALU_SRL, 32'd0, 32'h8000_0000, 5'd4);
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("alt%0d_grants", i), {30'd0, req1_ready, req0_ready}, {30'd0, exp_alt[i]});
            step();
        end
        check_eq("alt_rsp0_slt", rsp0_res, 32'd1);
        check_eq("alt_rsp1_srl", rsp1_res, 32'h0800_0000);

        // Backpressure on port 0 while port 1 keeps completing.
        rsp0_ready = 1'b0;
        req1_valid = 1'b0;
        set_req0(1'b1, ALU_AND, 32'h0000_FF00, 32'h0000_0F0F, 5'd0);
        settle();
        check_eq("bp_issue_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        set_req0(1'b1, ALU_ADD, 32'd2, 32'd3, 5'd0);
        set_req1(1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
            check_eq($sformatf("bp%0d_req1_ready", i), {31'd0, req1_ready}, 32'd1);
            step();
            check_eq($sformatf("bp%0d_rsp1_res", i), rsp1_res, 32'h0000_00FF);
            check_eq($sformatf("bp%0d_rsp0_res", i), rsp0_res, 32'h0000_0F00);
        end
        rsp0_ready = 1'b1;
        settle();
        check_eq("bp_release_req0_ready", {31'd0, req0_ready}, 32'd1);
        check_eq("bp_release_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        check_eq("bp_release_rsp0_res", rsp0_res, 32'd5);
        check_eq("bp_release_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);

        // Drain and refill every cycle.
        for (int i = 0; i < 4; i++) begin
            set_req0(1'b1, ALU_SLL, 32'd0, 32'd1, 5'(i));
            settle();
            check_eq($sformatf("stream%0d_req0_ready", i), {31'd0, req0_ready}, 32'd1);
            step();
            check_eq($sformatf("stream%0d_rsp0_res", i), rsp0_res, exp_sll[i]);
            check_eq($sformatf("stream%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd1);
        end
        req0_valid = 1'b0;
        step();
        check_eq("stream_end_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);

        // Reset in the cycle after a grant.
        rsp0_ready = 1'b0;
        set_req0(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0);
        settle();
        step();
        check_eq("rst_mid_rsp0_valid_before", {31'd0, rsp0_valid}, 32'd1);
        req0_valid = 1'b0;
        reset = 1'b1;
        settle();
        check_eq("rst_mid_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check_eq("rst_mid_rsp0_res", rsp0_res, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("rst_after_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);

`ifdef ALU_ARB_STATS_EN
        apply_reset();
        rsp1_ready = 1'b0;
        set_req1(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd0);
        settle();
        step();
        repeat (3) step();
        req1_valid = 1'b0;
        settle();
        check_eq("stats_wait1_cnt", {16'd0, wait1_cnt}, 32'd3);
        check_eq("stats_wait0_cnt", {16'd0, wait0_cnt}, 32'd0);
        req1_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        req1_valid = 1'b0;
        settle();
        check_eq("stats_wait1_sat", {16'd0, wait1_cnt}, 32'h0000_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
